// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier-side pipeline stages: derived
// width helpers and the accumulator state encoding.
package mul_pkg;

  // Accumulator width that holds max_len full-width products without wrapping.
  function automatic int acc_bits(input int n_bits, input int max_len);
    return 2 * n_bits + $clog2(max_len);
  endfunction

  function automatic int cnt_bits(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/mul_result_reg.sv
// Output holding register with a valid/ready handshake; the data is held
// stable until transferred, and a same-cycle load replaces a departing result.
module mul_result_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         valid_reg;
  logic [W-1:0] data_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;

endmodule

// File: rtl/mul_dot_accumulator.sv
// Sums bursts of multiplier products (delimited by in_last) into a wide
// accumulator and hands one registered dot-product result out per burst.
module mul_dot_accumulator
  import mul_pkg::*;
#(
  parameter  int N_BITS   = 15,
  parameter  int MAX_LEN  = 16,
  localparam int CNT_BITS = cnt_bits(MAX_LEN),
  localparam int ACC_BITS = acc_bits(N_BITS, MAX_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*N_BITS-1:0] in_prod,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ACC_BITS-1:0] out_sum,
  output logic [CNT_BITS-1:0] out_count,
  output logic                out_overflow
);

  localparam int RES_W = ACC_BITS + CNT_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = CNT_BITS'(MAX_LEN);

  acc_state_t          state_reg, state_next;
  logic [ACC_BITS-1:0] acc_reg, acc_next;
  logic [CNT_BITS-1:0] cnt_reg, cnt_next;
  logic                ovf_reg, ovf_next;

  logic                beat;
  logic                load;
  logic [ACC_BITS-1:0] load_sum;
  logic [CNT_BITS-1:0] load_cnt;
  logic                load_ovf;
  logic [ACC_BITS-1:0] prod_ext;
  logic [ACC_BITS-1:0] sum_plus;
  logic [CNT_BITS-1:0] cnt_plus;
  logic                at_max;
  logic [RES_W-1:0]    res_data;

  assign in_ready = !out_valid || out_ready;
  // A flushed cycle drops the beat even when the handshake itself completes.
  assign beat     = in_valid && in_ready && !flush;
  assign prod_ext = ACC_BITS'(in_prod);
  assign sum_plus = acc_reg + prod_ext;
  assign at_max   = (cnt_reg == CNT_MAX);
  assign cnt_plus = at_max ? cnt_reg : cnt_reg + CNT_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      ovf_reg   <= ovf_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    load       = 1'b0;
    load_sum   = '0;
    load_cnt   = '0;
    load_ovf   = 1'b0;
    if (flush) begin
      state_next = ST_IDLE;
      acc_next   = '0;
      cnt_next   = '0;
      ovf_next   = 1'b0;
    end else if (beat) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (in_last) begin
            load     = 1'b1;
            load_sum = prod_ext;
            load_cnt = CNT_BITS'(1);
          end else begin
            state_next = ST_ACC;
            acc_next   = prod_ext;
            cnt_next   = CNT_BITS'(1);
          end
        end
        ST_ACC: begin
          if (in_last) begin
            load       = 1'b1;
            load_sum   = sum_plus;
            load_cnt   = cnt_plus;
            load_ovf   = ovf_reg || at_max;
            state_next = ST_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
          end else begin
            acc_next = sum_plus;
            cnt_next = cnt_plus;
            ovf_next = ovf_reg || at_max;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign res_data = {load_ovf, load_cnt, load_sum};

  mul_result_reg #(.W(RES_W)) u_result (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (res_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  ({out_overflow, out_count, out_sum})
  );

endmodule

// File: doc/mul_dot_accumulator.md
Name: mul_dot_accumulator

Overview:
- Sequential stage directly downstream of the combinational Karatsuba multiplier.
- Consumes a stream of 2*N_BITS-bit products over a valid/ready handshake and sums each burst, delimited by in_last, into a wide accumulator.
- Presents one dot-product result per burst on a held output register with its own valid/ready handshake.
- Turns the purely combinational multiplier into a usable MAC pipeline stage.

Parameters:
- N_BITS, 15, operand width of the upstream multiplier; product width is 2*N_BITS.
- MAX_LEN, 16, maximum beats per burst without overflow; must be at least 2.
- CNT_BITS, $clog2(MAX_LEN+1), beat counter width (derived localparam).
- ACC_BITS, 2*N_BITS+$clog2(MAX_LEN), accumulator/result width (derived localparam).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- flush, input, 1, synchronous abort of the burst in progress.
- in_valid, input, 1, product beat valid.
- in_ready, output, 1, stage can accept a beat this cycle.
- in_prod, input, 2*N_BITS, product from the multiplier (c output).
- in_last, input, 1, final beat of the burst.
- out_valid, output, 1, result register holds a result.
- out_ready, input, 1, downstream accepts the result.
- out_sum, output, ACC_BITS, burst sum.
- out_count, output, CNT_BITS, number of beats in the burst, saturating at MAX_LEN.
- out_overflow, output, 1, burst exceeded MAX_LEN beats.

Behaviour:
- Clocking and reset
  - One clock domain; reset is synchronous and active-high (clk, rst). No asynchronous logic.
  - Reset clears state to IDLE, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0, out_overflow=0.
  - rst overrides every other input, including mid-burst and while out_valid=1; a pending result is discarded.
- Handshakes
  - in_ready = !out_valid || out_ready. Combinational; has no dependence on in_valid.
  - A beat is accepted when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- States
  - IDLE: no beats accumulated.
    - Accepted beat with in_last=0: acc<=in_prod, cnt<=1, go to ACC.
    - Accepted beat with in_last=1: load the result directly (single-beat burst), stay in IDLE.
  - ACC: burst in progress.
    - Accepted beat: acc<=acc+in_prod (ACC_BITS-wide, zero-extended).
    - Counter: cnt<=cnt+1, saturating at MAX_LEN; if cnt==MAX_LEN already, set ovf<=1.
    - Sum arithmetic wraps modulo 2^ACC_BITS after overflow.
    - Accepted beat with in_last=1: load the result register with final sum, count and overflow; clear acc/cnt/ovf; go to IDLE.
- Result register
  - Loaded one cycle after the last beat is accepted (latency 1).
  - out_* hold stable while out_valid && !out_ready.
  - out_valid clears on transfer unless a new result loads in the same cycle, in which case it stays 1 with the new data.
  - Back-to-back single-beat bursts sustain one result per cycle when out_ready=1.
- Flush
  - Clears acc/cnt/ovf and returns to IDLE.
  - Any beat presented in the same cycle is dropped, even if the handshake completes.
  - Does not affect a result already in the output register.
- Simultaneous events: rst > flush > beat acceptance. Output transfer and result load in the same cycle is legal, per the result-register rule above.
- No combinational path from in_prod to out_sum.

Decomposition:
- Shared package mul_pkg holds:
  - localparam functions acc_bits(n_bits, max_len) and cnt_bits(max_len);
  - state encoding constants ST_IDLE=1'b0, ST_ACC=1'b1.
- One natural sub-module: mul_result_reg, the output holding register with valid/ready, reusable behind other multiplier stages.
- The adder uses plain '+' at ACC_BITS width. The existing pos_add is not used, because its output width is fixed per operand widths.

Test Plan:
- Reset mid-burst: after beats 15 and 20 (no last), assert rst → next cycle all outputs 0, in_ready=1; a fresh burst of 7 (last) then gives out_sum=7, out_count=1.
- Dot product: beats 3*5=15, 100*200=20000, 32767*32767=1073676289 (last), out_ready=1 → one cycle after last, out_valid=1, out_sum=1073696304, out_count=3, out_overflow=0.
- Backpressure: result pending with out_ready=0 for 5 cycles → in_ready=0, out_sum stable; raise out_ready → transfer, in_ready=1 in the same cycle.
- Back-to-back singles: in_last=1 every cycle with products 1,2,3,4, out_ready=1 → out_sum sequence 1,2,3,4 on consecutive cycles, no bubbles.
- Overflow: MAX_LEN+1=17 beats of 2^30-1 → out_overflow=1, out_count=16, out_sum=(17*(2^30-1)) mod 2^34.
- Flush: beats 10, 20, then flush with beat 99 valid, then beat 5 (last) → out_sum=5, out_count=1.
